cv32e40p_clk_gate_ctrl: RTL and testbench

CV32E40P_CLK_GATE_CTRL -- requirements
Module: cv32e40p_clk_gate_ctrl

---
 rtl/cv32e40p_clk_gate_pkg.sv | 15 +
 rtl/cv32e40p_clk_gate_ctrl.sv | 124 ++++++++++++
 tb/tb_cv32e40p_clk_gate_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_clk_gate_pkg.sv
// Shared types and counter widths for the core clock-gate controller.
package cv32e40p_clk_gate_pkg;

  localparam int IDLE_CNT_W = 8;
  localparam int WAKE_CNT_W = 4;

  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    RUN        = 3'd1,
    DRAIN      = 3'd2,
    GATED      = 3'd3,
    WAKE       = 3'd4
  } cg_state_e;

endpackage

// File: rtl/cv32e40p_clk_gate_ctrl.sv
// Core clock-gate controller: drains the pipeline, gates the clock, wakes up; all outputs registered.
// Optional gated-cycle statistics counter behind macro CV32E40P_CG_STATS_EN.
module cv32e40p_clk_gate_ctrl
  import cv32e40p_clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 4,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable_i,
  input  logic        sleep_req_i,
  input  logic        core_busy_i,
  input  logic        wake_i,
  output logic        clock_en_o,
  output logic        core_sleep_o,
  output logic        sleep_ack_o
`ifdef CV32E40P_CG_STATS_EN
  ,
  output logic [31:0] gated_cycles_o
`endif
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_CNT_W-1:0] IDLE_ONE  = IDLE_CNT_W'(1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_ONE  = WAKE_CNT_W'(1);

  cg_state_e             state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  clock_en_d, core_sleep_d, sleep_ack_d;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      RESET_WAIT: begin
        if (fetch_enable_i) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      RUN: begin
        if (sleep_req_i && !wake_i) begin
          state_d    = DRAIN;
          idle_cnt_d = '0;
        end
      end
      DRAIN: begin
        // Abort beats idle counting so a late interrupt never gets gated.
        if (wake_i || !sleep_req_i) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else if (core_busy_i) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_ONE;
        end
      end
      GATED: begin
        if (wake_i) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_ONE;
        end
      end
      default: begin
        state_d    = RESET_WAIT;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state and then flopped, so they track the state with no glitches.
    clock_en_d   = (state_d == RUN) || (state_d == DRAIN) || (state_d == WAKE);
    core_sleep_d = (state_d == RESET_WAIT) || (state_d == GATED) || (state_d == WAKE);
    sleep_ack_d  = (state_q == DRAIN) && (state_d == GATED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_WAIT;
      idle_cnt_q   <= '0;
      wake_cnt_q   <= '0;
      clock_en_o   <= 1'b0;
      core_sleep_o <= 1'b1;
      sleep_ack_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_cnt_q   <= wake_cnt_d;
      clock_en_o   <= clock_en_d;
      core_sleep_o <= core_sleep_d;
      sleep_ack_o  <= sleep_ack_d;
    end
  end

`ifdef CV32E40P_CG_STATS_EN
  logic [31:0] gated_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cnt_q <= '0;
    end else if (state_q == GATED) begin
      gated_cnt_q <= gated_cnt_q + 32'd1;
    end
  end

  assign gated_cycles_o = gated_cnt_q;
`endif

endmodule

// File: tb/tb_cv32e40p_clk_gate_ctrl.sv
// Directed bench for cv32e40p_clk_gate_ctrl; statistics checks only when CV32E40P_CG_STATS_EN is defined.
module tb_cv32e40p_clk_gate_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic fetch_enable_i, sleep_req_i, core_busy_i, wake_i;
  logic clock_en_o, core_sleep_o, sleep_ack_o;
`ifdef CV32E40P_CG_STATS_EN
  logic [31:0] gated_cycles_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40p_clk_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_enable_i (fetch_enable_i),
    .sleep_req_i    (sleep_req_i),
    .core_busy_i    (core_busy_i),
    .wake_i         (wake_i),
    .clock_en_o     (clock_en_o),
    .core_sleep_o   (core_sleep_o),
    .sleep_ack_o    (sleep_ack_o)
`ifdef CV32E40P_CG_STATS_EN
    ,
    .gated_cycles_o (gated_cycles_o)
`endif
  );

  typedef struct {
    logic fe, sr, busy, wake;
    logic en, sl, ack;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic fe, sr, busy, wake, en, sl, ack);
    vec_t v;
    v.fe = fe; v.sr = sr; v.busy = busy; v.wake = wake;
    v.en = en; v.sl = sl; v.ack = ack;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fe, sr, busy, wake);
    fetch_enable_i = fe; sleep_req_i = sr; core_busy_i = busy; wake_i = wake;
  endtask

  // Apply inputs, cross one rising edge, then sample 1 time unit later.
  task automatic tick(input logic fe, sr, busy, wake);
    drive(fe, sr, busy, wake);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic en, sl, ack);
    chk({tag, ".clock_en"}, {31'd0, clock_en_o}, {31'd0, en});
    chk({tag, ".core_sleep"}, {31'd0, core_sleep_o}, {31'd0, sl});
    chk({tag, ".sleep_ack"}, {31'd0, sleep_ack_o}, {31'd0, ack});
  endtask

  initial begin
    // fe sr busy wake | en sl ack   (outputs after the edge)
    add(0,0,0,0, 0,1,0);  // RESET_WAIT holds
    add(0,0,0,0, 0,1,0);
    add(1,0,0,0, 1,1,0);  // WAKE cycle 1
    add(0,0,0,0, 1,1,0);  // WAKE cycle 2, fetch_enable no longer matters
    add(0,1,0,1, 1,0,0);  // RUN; sleep/wake ignored in WAKE
    add(0,1,0,0, 1,0,0);  // DRAIN idle 0
    add(0,1,0,0, 1,0,0);  // idle 1
    add(0,1,0,0, 1,0,0);  // idle 2
    add(0,1,0,0, 1,0,0);  // idle 3
    add(0,1,0,0, 0,1,1);  // GATED entry pulse
    add(0,1,0,0, 0,1,0);  // pulse is single-cycle
    add(0,0,0,0, 0,1,0);  // request drop ignored in GATED
    add(0,0,0,1, 1,1,0);  // WAKE
    add(0,0,0,0, 1,1,0);
    add(0,0,0,0, 1,0,0);  // RUN
    add(0,1,0,0, 1,0,0);  // DRAIN idle 0
    add(0,1,0,0, 1,0,0);  // idle 1
    add(0,1,0,0, 1,0,0);  // idle 2
    add(0,1,1,0, 1,0,0);  // busy on 3rd idle cycle restarts count
    add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 1,0,0);
    add(0,1,0,0, 0,1,1);  // GATED 4 idle cycles after the pulse
    add(0,0,0,1, 1,1,0);  // WAKE
    add(0,0,0,0, 1,1,0);
    add(0,0,0,0, 1,0,0);  // RUN
    add(0,1,0,0, 1,0,0);  // DRAIN
    add(0,1,0,0, 1,0,0);
    add(0,1,0,1, 1,0,0);  // wake mid-DRAIN -> RUN, no ack
    add(0,1,0,0, 1,0,0);  // DRAIN again
    add(0,0,0,0, 1,0,0);  // request dropped -> RUN
    add(0,1,0,1, 1,0,0);  // wake blocks DRAIN entry
    add(0,0,0,0, 1,0,0);

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 1, 0);
`ifdef CV32E40P_CG_STATS_EN
    chk("reset.gated_cycles", gated_cycles_o, 32'd0);
`endif
    rst_n = 1'b1;

    foreach (vq[i]) begin
      tick(vq[i].fe, vq[i].sr, vq[i].busy, vq[i].wake);
      chk_out($sformatf("vec%0d", i), vq[i].en, vq[i].sl, vq[i].ack);
    end

    // From RUN: 1 edge into DRAIN, 4 idle edges into GATED, then wake.
    repeat (5) tick(0, 1, 0, 0);
    chk_out("pre_async.gated", 0, 1, 1);
    tick(0, 0, 0, 1);
    chk_out("pre_async.wake", 1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset_mid_wake", 0, 1, 0);
    #3;
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("held_in_reset", 0, 1, 0);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    chk_out("post_reset_wait", 0, 1, 0);

`ifdef CV32E40P_CG_STATS_EN
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    repeat (5) tick(0, 1, 0, 0);
    chk_out("stats.gated", 0, 1, 1);
    repeat (9) tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    chk("stats.ten_cycles", gated_cycles_o, 32'd10);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    repeat (5) tick(0, 1, 0, 0);
    dut.gated_cnt_q = 32'hFFFF_FFFF;
    tick(0, 0, 0, 1);
    chk("stats.wrap", gated_cycles_o, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
